// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared AXI4-Lite definitions for the command master: response codes,
// fixed bus geometry and the completion record returned to the command side.
package axi_lite_cmd_master_pkg;

    localparam int AXIL_DATA_WIDTH = 64;
    localparam int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8;
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic                       write;
        logic [AXIL_DATA_WIDTH-1:0] rdata;
        logic [1:0]                 resp;
    } cpl_t;

    function automatic cpl_t write_cpl(input logic [1:0] bresp);
        cpl_t c;
        c.write = 1'b1;
        c.rdata = '0;
        c.resp  = bresp;
        return c;
    endfunction

    function automatic cpl_t read_cpl(input logic [AXIL_DATA_WIDTH-1:0] rdata,
                                      input logic [1:0] rresp);
        cpl_t c;
        c.write = 1'b0;
        c.rdata = rdata;
        c.resp  = rresp;
        return c;
    endfunction

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator with a single outstanding transaction: converts one
// valid/ready command into one AXI4-Lite write or read and returns a completion.
module axi_lite_cmd_master
    import axi_lite_cmd_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      busy,

    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp
);

    generate
        if (DATA_WIDTH != AXIL_DATA_WIDTH) begin : g_bad_width
            $error("axi_lite_cmd_master: DATA_WIDTH must be 64");
        end
    endgenerate

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_DATA = 3'd4;
    localparam logic [2:0] ST_CPL     = 3'd5;

    logic [2:0]              state;
    logic                    aw_done;
    logic                    w_done;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    cpl_t                    cpl_q;

    logic cmd_accept;
    logic aw_hs;
    logic w_hs;

    assign cmd_accept = cmd_valid && cmd_ready;
    assign aw_hs      = m_axi_awvalid && m_axi_awready;
    assign w_hs       = m_axi_wvalid && m_axi_wready;

    // AW and W complete independently; the done flags retire each channel's
    // valid on its own handshake and the write moves on once both are in.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            cpl_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        state   <= cmd_write ? ST_WR_REQ : ST_RD_REQ;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                ST_WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) state <= ST_WR_RESP;
                end
                ST_WR_RESP: begin
                    if (m_axi_bvalid) begin
                        cpl_q <= write_cpl(m_axi_bresp);
                        state <= ST_CPL;
                    end
                end
                ST_RD_REQ: begin
                    if (m_axi_arready) state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (m_axi_rvalid) begin
                        cpl_q <= read_cpl(m_axi_rdata, m_axi_rresp);
                        state <= ST_CPL;
                    end
                end
                ST_CPL: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Command payload only changes on accept, so it stays stable for the
    // whole time any request valid is high.
    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);

    assign m_axi_awvalid = (state == ST_WR_REQ) && !aw_done;
    assign m_axi_wvalid  = (state == ST_WR_REQ) && !w_done;
    assign m_axi_bready  = (state == ST_WR_RESP);
    assign m_axi_arvalid = (state == ST_RD_REQ);
    assign m_axi_rready  = (state == ST_RD_DATA);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;

    assign rsp_valid     = (state == ST_CPL);
    assign rsp_write     = cpl_q.write;
    assign rsp_rdata     = cpl_q.rdata;
    assign rsp_resp      = cpl_q.resp;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: drives directed commands into the master,
// which talks to a 64-bit AXI4-Lite register slave model with programmable delays.
module tb_axi_lite_cmd_master;
    import axi_lite_cmd_master_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic [7:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [63:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Register slave model: 16 x 64-bit registers, ready delays counted in
    // cycles of valid-high before ready, B delay counted after both AW and W.
    logic [63:0] mem [16] = '{default: '0};
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_val = AXI_RESP_OKAY, rresp_val = AXI_RESP_OKAY;
    int          aw_wait, w_wait, b_wait, ar_wait;
    logic        aw_got, w_got;
    logic [31:0] s_awaddr;
    logic [63:0] s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_aw_hs, s_w_hs;
    logic [31:0] cur_addr;
    logic [63:0] cur_data;
    logic [7:0]  cur_strb;

    assign m_axi_awready = m_axi_awvalid && !aw_got && (aw_wait >= aw_delay);
    assign m_axi_wready  = m_axi_wvalid && !w_got && (w_wait >= w_delay);
    assign m_axi_arready = m_axi_arvalid && !m_axi_rvalid && (ar_wait >= ar_delay);
    assign s_aw_hs  = m_axi_awvalid && m_axi_awready;
    assign s_w_hs   = m_axi_wvalid && m_axi_wready;
    assign cur_addr = aw_got ? s_awaddr : m_axi_awaddr;
    assign cur_data = w_got ? s_wdata : m_axi_wdata;
    assign cur_strb = w_got ? s_wstrb : m_axi_wstrb;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            aw_got <= 1'b0; w_got <= 1'b0; m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0;
            m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
        end else begin
            if (s_aw_hs) begin aw_got <= 1'b1; s_awaddr <= m_axi_awaddr; aw_wait <= 0; end
            else if (m_axi_awvalid) aw_wait <= aw_wait + 1;
            if (s_w_hs) begin w_got <= 1'b1; s_wdata <= m_axi_wdata; s_wstrb <= m_axi_wstrb; w_wait <= 0; end
            else if (m_axi_wvalid) w_wait <= w_wait + 1;
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !m_axi_bvalid) begin
                if (b_wait >= b_delay) begin
                    mem[cur_addr[6:3]] <= merge(mem[cur_addr[6:3]], cur_data, cur_strb);
                    m_axi_bvalid <= 1'b1; m_axi_bresp <= bresp_val; b_wait <= 0;
                    aw_got <= 1'b0; w_got <= 1'b0;
                end else b_wait <= b_wait + 1;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1; m_axi_rdata <= mem[m_axi_araddr[6:3]];
                m_axi_rresp <= rresp_val; ar_wait <= 0;
            end else if (m_axi_arvalid) ar_wait <= ar_wait + 1;
        end
    end

    // Scoreboard of expected completions, popped by the monitor on each rsp handshake.
    typedef struct { logic write; logic [63:0] rdata; logic [1:0] resp; } exp_t;
    exp_t sb[$];

    int cyc = 0, accept_cnt = 0, accept_cyc = 0, cpl_cnt = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0, rsp_first_cyc = 0, rsp_hs_cyc = 0;
    int aw_hi = 0, w_hi = 0, aw_len = 0, w_len = 0;
    logic [7:0]  last_wstrb = '0;
    logic        prev_awv = 0, prev_aw_hs = 0, prev_wv = 0, prev_w_hs = 0, prev_rspv = 0, prev_rspr = 0;
    logic [31:0] prev_awaddr = '0;
    logic [71:0] prev_w = '0;
    logic [66:0] prev_payload = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            prev_awv = 0; prev_aw_hs = 0; prev_wv = 0; prev_w_hs = 0;
            prev_rspv = 0; prev_rspr = 0; aw_hi = 0; w_hi = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin accept_cnt++; accept_cyc = cyc; end
            if (m_axi_awvalid) begin
                if (prev_awv && !prev_aw_hs) check_output("awaddr_stable", m_axi_awaddr, prev_awaddr);
                aw_hi++;
                if (m_axi_awready) begin aw_len = aw_hi; aw_hi = 0; aw_hs_cyc = cyc; end
            end
            if (m_axi_wvalid) begin
                if (prev_wv && !prev_w_hs) check_output("wdata_stable", {m_axi_wdata, m_axi_wstrb}, prev_w);
                w_hi++;
                if (m_axi_wready) begin w_len = w_hi; w_hi = 0; w_hs_cyc = cyc; last_wstrb = m_axi_wstrb; end
            end
            prev_awv = m_axi_awvalid; prev_aw_hs = m_axi_awvalid && m_axi_awready; prev_awaddr = m_axi_awaddr;
            prev_wv = m_axi_wvalid; prev_w_hs = m_axi_wvalid && m_axi_wready; prev_w = {m_axi_wdata, m_axi_wstrb};
            if (m_axi_arvalid && m_axi_arready) ar_hs_cyc = cyc;
            if (rsp_valid && !prev_rspv) rsp_first_cyc = cyc;
            if (prev_rspv && !prev_rspr) begin
                check_output("rsp_valid_held", rsp_valid, 1'b1);
                check_output("rsp_payload_stable", {rsp_write, rsp_rdata, rsp_resp}, prev_payload);
                check_output("cmd_ready_in_cpl", cmd_ready, 1'b0);
            end
            if (rsp_valid && rsp_ready) begin
                cpl_cnt++; rsp_hs_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_rsp: got completion write=%0d resp=%0d with none expected", rsp_write, rsp_resp);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("rsp_write", rsp_write, e.write);
                    check_output("rsp_rdata", rsp_rdata, e.rdata);
                    check_output("rsp_resp", rsp_resp, e.resp);
                end
            end
            prev_rspv = rsp_valid; prev_rspr = rsp_ready; prev_payload = {rsp_write, rsp_rdata, rsp_resp};
        end
    end

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [63:0] d,
                                  input logic [7:0] s, input logic expect_rsp,
                                  input logic [63:0] exp_rdata, input logic [1:0] exp_resp);
        exp_t e;
        int   start;
        int   n;
        if (expect_rsp) begin
            e.write = wr; e.rdata = exp_rdata; e.resp = exp_resp;
            sb.push_back(e);
        end
        cmd_write = wr; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        start = accept_cnt;
        n = 0;
        while (accept_cnt == start && n < 60) begin @(posedge clk); #1; n++; end
        if (accept_cnt == start) begin
            checks++; errors++;
            $display("[TB] FAIL cmd_accept timeout: addr 0x%0h not accepted", addr);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string name);
        int n;
        n = 0;
        while (cpl_cnt < target && n < 100) begin @(posedge clk); #1; n++; end
        if (cpl_cnt < target) begin
            checks++; errors++;
            $display("[TB] FAIL %s timeout: completions %0d expected %0d", name, cpl_cnt, target);
        end
    endtask

    initial begin
        int c0;
        int n;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        check_output("reset_cmd_ready", cmd_ready, 1'b1);
        check_output("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 6'b0);
        check_output("reset_payload", {rsp_write, rsp_rdata, rsp_resp}, 67'b0);
        check_output("reset_busy", busy, 1'b0);

        // Zero-wait write then readback
        apply_stimulus(1'b1, 32'h10, 64'h1122334455667788, 8'hFF, 1'b1, 64'h0, AXI_RESP_OKAY);
        wait_rsp(1, "t1_write");
        check_output("t1_aw_latency", aw_hs_cyc - accept_cyc, 1);
        check_output("t1_w_latency", w_hs_cyc - accept_cyc, 1);
        check_output("t1_wr_rsp_latency", rsp_first_cyc - accept_cyc, 3);
        apply_stimulus(1'b0, 32'h10, 64'h0, 8'h0, 1'b1, 64'h1122334455667788, AXI_RESP_OKAY);
        wait_rsp(2, "t1_read");
        check_output("t1_ar_latency", ar_hs_cyc - accept_cyc, 1);
        check_output("t1_rd_rsp_latency", rsp_first_cyc - accept_cyc, 3);

        // Partial strobe into a zeroed register
        apply_stimulus(1'b1, 32'h18, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b1, 64'h0, AXI_RESP_OKAY);
        wait_rsp(3, "t2_write");
        check_output("t2_slave_wstrb", last_wstrb, 8'h0F);
        apply_stimulus(1'b0, 32'h18, 64'h0, 8'h0, 1'b1, 64'h00000000BBBBBBBB, AXI_RESP_OKAY);
        wait_rsp(4, "t2_read");

        // AW delayed, then W delayed
        aw_delay = 2;
        c0 = cpl_cnt;
        apply_stimulus(1'b1, 32'h20, 64'h0102030405060708, 8'hFF, 1'b1, 64'h0, AXI_RESP_OKAY);
        wait_rsp(c0 + 1, "t3_aw_delay");
        repeat (5) @(posedge clk); #1;
        check_output("t3_awvalid_cycles", aw_len, 3);
        check_output("t3_wvalid_cycles", w_len, 1);
        check_output("t3_single_cpl", cpl_cnt, c0 + 1);
        aw_delay = 0; w_delay = 2;
        c0 = cpl_cnt;
        apply_stimulus(1'b1, 32'h28, 64'hCAFEF00D12345678, 8'hFF, 1'b1, 64'h0, AXI_RESP_OKAY);
        wait_rsp(c0 + 1, "t3_w_delay");
        repeat (5) @(posedge clk); #1;
        check_output("t3b_awvalid_cycles", aw_len, 1);
        check_output("t3b_wvalid_cycles", w_len, 3);
        check_output("t3b_single_cpl", cpl_cnt, c0 + 1);
        w_delay = 0;
        apply_stimulus(1'b0, 32'h28, 64'h0, 8'h0, 1'b1, 64'hCAFEF00D12345678, AXI_RESP_OKAY);
        wait_rsp(c0 + 2, "t3_read");

        // Error responses pass through unchanged
        bresp_val = AXI_RESP_SLVERR;
        apply_stimulus(1'b1, 32'h30, 64'h5555, 8'hFF, 1'b1, 64'h0, AXI_RESP_SLVERR);
        wait_rsp(c0 + 3, "t4_slverr");
        check_output("t4_idle_after_slverr", cmd_ready, 1'b1);
        bresp_val = AXI_RESP_OKAY; rresp_val = AXI_RESP_DECERR;
        apply_stimulus(1'b0, 32'h10, 64'h0, 8'h0, 1'b1, 64'h1122334455667788, AXI_RESP_DECERR);
        wait_rsp(c0 + 4, "t4_decerr");
        check_output("t4_idle_after_decerr", cmd_ready, 1'b1);
        rresp_val = AXI_RESP_OKAY;

        // Completion back-pressure, next command queued behind it
        rsp_ready = 1'b0;
        c0 = cpl_cnt;
        apply_stimulus(1'b0, 32'h20, 64'h0, 8'h0, 1'b1, 64'h0102030405060708, AXI_RESP_OKAY);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        check_output("t5_rsp_valid_seen", rsp_valid, 1'b1);
        fork
            apply_stimulus(1'b0, 32'h18, 64'h0, 8'h0, 1'b1, 64'h00000000BBBBBBBB, AXI_RESP_OKAY);
            begin repeat (5) @(posedge clk); #1 rsp_ready = 1'b1; end
        join
        check_output("t5_hold_cycles", rsp_hs_cyc - rsp_first_cyc, 5);
        check_output("t5_next_accept", accept_cyc - rsp_hs_cyc, 1);
        wait_rsp(c0 + 2, "t5_second");

        // Reset while waiting for B: no completion, clean idle afterwards
        b_delay = 4;
        c0 = cpl_cnt;
        apply_stimulus(1'b1, 32'h38, 64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0, 64'h0, AXI_RESP_OKAY);
        n = 0;
        while (!m_axi_bready && n < 20) begin @(posedge clk); #1; n++; end
        check_output("t6_in_wr_resp", m_axi_bready, 1'b1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check_output("t6_valids_after_reset", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, 6'b0);
        check_output("t6_cmd_ready_after_reset", cmd_ready, 1'b1);
        b_delay = 0;
        repeat (6) @(posedge clk); #1;
        check_output("t6_no_cpl", cpl_cnt, c0);
        apply_stimulus(1'b0, 32'h10, 64'h0, 8'h0, 1'b1, 64'h1122334455667788, AXI_RESP_OKAY);
        wait_rsp(c0 + 1, "t6_read");

        repeat (5) @(posedge clk); #1;
        check_output("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
